cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates I-cache fills and D-cache fills/writebacks onto one burst memory port.
// Optional ARB_PERF_CNT_EN adds grant and wait performance counters.
module cache_arbiter #(
  parameter int S_LINE       = 256,
  parameter int S_BURST      = 64,
  parameter int D_STREAK_MAX = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pmem_read,
  input  logic [31:0]        i_pmem_address,
  output logic [S_LINE-1:0]  i_pmem_rdata,
  output logic               i_pmem_resp,
  input  logic               d_pmem_read,
  input  logic               d_pmem_write,
  input  logic [31:0]        d_pmem_address,
  input  logic [S_LINE-1:0]  d_pmem_wdata,
  output logic [S_LINE-1:0]  d_pmem_rdata,
  output logic               d_pmem_resp,
`ifdef ARB_PERF_CNT_EN
  output logic [23:0]        i_grant_cnt,
  output logic [23:0]        d_grant_cnt,
  output logic [23:0]        wait_cnt,
`endif
  output logic               bmem_read,
  output logic               bmem_write,
  output logic [31:0]        bmem_address,
  output logic [S_BURST-1:0] bmem_wdata,
  input  logic [S_BURST-1:0] bmem_rdata,
  input  logic               bmem_resp
);
  localparam int NB   = S_LINE / S_BURST;
  localparam int KW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int OFFW = $clog2(S_LINE / 8);
  localparam int SW   = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(NB - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
  localparam logic [31:0]   ADDR_MASK  = ~((32'd1 << OFFW) - 32'd1);

  // IDLE arbitrate | I_RD, D_RD read burst | D_WR write burst | DONE one-cycle resp to owner
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] I_RD = 3'd1;
  localparam logic [2:0] D_RD = 3'd2;
  localparam logic [2:0] D_WR = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]        state;
  logic              owner_d;
  logic [KW-1:0]     k;
  logic [SW-1:0]     d_streak;
  logic [31:0]       addr_q;
  logic [S_LINE-1:0] line_q;
  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  always_comb begin
    i_req   = i_pmem_read;
    d_req   = d_pmem_read | d_pmem_write;
    grant_i = (state == IDLE) && i_req && (!d_req || (d_streak == STREAK_MAX));
    grant_d = (state == IDLE) && d_req && !grant_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      k        <= '0;
      d_streak <= '0;
      addr_q   <= '0;
      line_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state    <= I_RD;
            owner_d  <= 1'b0;
            addr_q   <= i_pmem_address & ADDR_MASK;
            d_streak <= '0;
          end else if (grant_d) begin
            // a simultaneous read+write request is serviced as the writeback
            state   <= d_pmem_write ? D_WR : D_RD;
            owner_d <= 1'b1;
            addr_q  <= d_pmem_address & ADDR_MASK;
            if (d_pmem_write) line_q <= d_pmem_wdata;
            if (d_streak != STREAK_MAX) d_streak <= d_streak + SW'(1);
          end
        end
        I_RD, D_RD, D_WR: begin
          if (bmem_resp) begin
            if (state != D_WR) line_q[int'(k)*S_BURST +: S_BURST] <= bmem_rdata;
            if (k == K_LAST) begin
              k     <= '0;
              state <= DONE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bmem_read    = (state == I_RD) || (state == D_RD);
  assign bmem_write   = (state == D_WR);
  assign bmem_address = addr_q;
  assign bmem_wdata   = line_q[int'(k)*S_BURST +: S_BURST];
  assign i_pmem_rdata = line_q;
  assign d_pmem_rdata = line_q;
  assign i_pmem_resp  = (state == DONE) && !owner_d;
  assign d_pmem_resp  = (state == DONE) && owner_d;

`ifdef ARB_PERF_CNT_EN
  logic i_wait;
  logic d_wait;

  always_comb begin
    i_wait = i_req && !((state == I_RD) || ((state == DONE) && !owner_d));
    d_wait = d_req && !((state == D_RD) || (state == D_WR) || ((state == DONE) && owner_d));
  end

  // 24-bit counters wrap naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      if (grant_i) i_grant_cnt <= i_grant_cnt + 24'd1;
      if (grant_d) d_grant_cnt <= d_grant_cnt + 24'd1;
      if (i_wait || d_wait) wait_cnt <= wait_cnt + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized scoreboard bench for cache_arbiter with a burst memory responder.
// Counter checks are compiled in when ARB_PERF_CNT_EN is defined.
module tb_cache_arbiter;
  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int NB      = S_LINE / S_BURST;
  localparam int DMAX    = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_pmem_read = 1'b0;
  logic [31:0]        i_pmem_address = '0;
  logic [S_LINE-1:0]  i_pmem_rdata;
  logic               i_pmem_resp;
  logic               d_pmem_read = 1'b0;
  logic               d_pmem_write = 1'b0;
  logic [31:0]        d_pmem_address = '0;
  logic [S_LINE-1:0]  d_pmem_wdata = '0;
  logic [S_LINE-1:0]  d_pmem_rdata;
  logic               d_pmem_resp;
  logic               bmem_read;
  logic               bmem_write;
  logic [31:0]        bmem_address;
  logic [S_BURST-1:0] bmem_wdata;
  logic [S_BURST-1:0] bmem_rdata = '0;
  logic               bmem_resp = 1'b0;
`ifdef ARB_PERF_CNT_EN
  logic [23:0]        i_grant_cnt;
  logic [23:0]        d_grant_cnt;
  logic [23:0]        wait_cnt;
`endif

  always #5 clk = ~clk;

  cache_arbiter #(.S_LINE(S_LINE), .S_BURST(S_BURST), .D_STREAK_MAX(DMAX)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
`ifdef ARB_PERF_CNT_EN
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .wait_cnt(wait_cnt),
`endif
    .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_address(bmem_address),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  typedef struct {
    bit          is_d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [S_LINE-1:0] wdata;
  } item_t;

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [31:0] addr;
    logic [S_LINE-1:0] data;
  } exp_t;

  int    checks = 0;
  int    failures = 0;
  item_t i_items[$];
  item_t d_items[$];
  item_t sc_i[$];
  item_t sc_d[$];
  exp_t  exp_q[$];
  bit    obs_own[$];
  logic [S_LINE-1:0] ref_mem [logic [31:0]];
  logic [S_LINE-1:0] bus_mem [logic [31:0]];
  int    m_streak = 0;
  int    m_igr = 0;
  int    m_dgr = 0;
  bit    drv_en = 1'b0;
  bit    mon_en = 1'b1;
  bit    spur_en = 1'b0;
  bit    own_i = 1'b0;
  bit    own_d = 1'b0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [S_LINE-1:0] default_line(input logic [31:0] a);
    logic [S_LINE-1:0] l;
    for (int i = 0; i < S_LINE/32; i++) l[i*32 +: 32] = a ^ (32'h0101_0101 * i) ^ 32'hC3C3_0000;
    return l;
  endfunction

  function automatic logic [S_LINE-1:0] rand_line();
    logic [S_LINE-1:0] l;
    for (int i = 0; i < S_LINE/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic item_t mk(input bit is_d, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [S_LINE-1:0] wd);
    item_t it;
    it.is_d = is_d; it.rd = rd; it.wr = wr; it.addr = addr; it.wdata = wd;
    return it;
  endfunction

  function automatic logic [639:0] all_outs();
    logic [639:0] v;
    v = 640'({i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
              bmem_read, bmem_write, bmem_address, bmem_wdata});
`ifdef ARB_PERF_CNT_EN
    v = v | 640'({i_grant_cnt, d_grant_cnt, wait_cnt});
`endif
    return v;
  endfunction

  // Burst memory: NB consecutive beats after a random 0..2 cycle delay, stray resp when idle.
  initial begin
    int beat = 0;
    int dly = 0;
    bit busy = 1'b0;
    bit wr_cmd = 1'b0;
    logic [31:0] a = '0;
    logic [S_LINE-1:0] line = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 1'b0;
        bmem_resp = 1'b0;
      end else begin
        if (!busy) begin
          bmem_resp = 1'b0;
          if (bmem_read || bmem_write) begin
            busy = 1'b1; beat = 0; dly = $urandom_range(0, 2);
            a = bmem_address; wr_cmd = bmem_write;
            line = bus_mem.exists(a) ? bus_mem[a] : default_line(a);
          end else if (spur_en && $urandom_range(0, 7) == 0) begin
            bmem_resp = 1'b1;
            bmem_rdata = {$urandom, $urandom};
          end
        end
        if (busy) begin
          if (dly > 0) begin
            dly--;
            bmem_resp = 1'b0;
          end else begin
            bmem_resp = 1'b1;
            bmem_rdata = line[beat*S_BURST +: S_BURST];
            if (wr_cmd) line[beat*S_BURST +: S_BURST] = bmem_wdata;
            beat++;
            if (beat == NB) begin
              busy = 1'b0;
              if (wr_cmd) bus_mem[a] = line;
            end
          end
        end
      end
    end
  end

  // Monitor: pops an expectation at each burst start, checks beats and the resp cycle.
  initial begin
    bit prev = 1'b0;
    bit have_cur = 1'b0;
    bit want_resp = 1'b0;
    int beat = 0;
    exp_t cur;
    forever begin
      @(negedge clk); #1;
      if (!rst || !mon_en) begin
        prev = 1'b0; have_cur = 1'b0; want_resp = 1'b0; beat = 0;
        own_i = 1'b0; own_d = 1'b0;
      end else begin
        if (want_resp) begin
          chk("resp_sel", 640'({i_pmem_resp, d_pmem_resp}), 640'({!cur.is_d, cur.is_d}));
          if (!cur.is_wr)
            chk(cur.is_d ? "d_rdata" : "i_rdata", 640'(cur.is_d ? d_pmem_rdata : i_pmem_rdata),
                640'(cur.data));
          if (i_pmem_resp || d_pmem_resp) obs_own.push_back(d_pmem_resp);
          want_resp = 1'b0; have_cur = 1'b0; own_i = 1'b0; own_d = 1'b0;
        end else if (i_pmem_resp || d_pmem_resp) begin
          chk("resp_unexpected", 640'({i_pmem_resp, d_pmem_resp}), 640'(0));
        end
        if ((bmem_read || bmem_write) && !prev) begin
          if (exp_q.size() == 0) begin
            chk("cmd_unexpected", 640'({bmem_read, bmem_write}), 640'(0));
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1; beat = 0;
            own_i = !cur.is_d; own_d = cur.is_d;
            chk("cmd_start", 640'({bmem_read, bmem_write, bmem_address}),
                640'({!cur.is_wr, cur.is_wr, cur.addr}));
          end
        end else if ((bmem_read || bmem_write) && have_cur) begin
          chk("cmd_hold", 640'({bmem_read, bmem_write, bmem_address}),
              640'({!cur.is_wr, cur.is_wr, cur.addr}));
        end
        if ((bmem_read || bmem_write) && have_cur && bmem_resp) begin
          if (cur.is_wr) chk("wbeat", 640'(bmem_wdata), 640'(cur.data[beat*S_BURST +: S_BURST]));
          beat++;
          if (beat == NB) want_resp = 1'b1;
        end
        prev = bmem_read || bmem_write;
      end
    end
  end

  // Requesters hold their head item until resp; the owner scrambles its inputs mid-burst.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (drv_en && rst) begin
        if (i_pmem_resp && i_items.size() > 0) i_items.delete(0);
        if (d_pmem_resp && d_items.size() > 0) d_items.delete(0);
        if (i_items.size() == 0) begin
          i_pmem_read = 1'b0; i_pmem_address = $urandom;
        end else if (own_i) begin
          i_pmem_read = 1'($urandom_range(0, 1)); i_pmem_address = $urandom;
        end else begin
          i_pmem_read = 1'b1; i_pmem_address = i_items[0].addr;
        end
        if (d_items.size() == 0) begin
          d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = $urandom;
        end else if (own_d) begin
          d_pmem_read = 1'($urandom_range(0, 1)); d_pmem_write = 1'($urandom_range(0, 1));
          d_pmem_address = $urandom; d_pmem_wdata = rand_line();
        end else begin
          d_pmem_read = d_items[0].rd; d_pmem_write = d_items[0].wr;
          d_pmem_address = d_items[0].addr; d_pmem_wdata = d_items[0].wdata;
        end
      end
    end
  end

  // Reference: both requesters pending together; D wins unless I waits and the D streak is full.
  task automatic scenario();
    int ii = 0;
    int di = 0;
    int n = 0;
    while (ii < sc_i.size() || di < sc_d.size()) begin
      item_t it;
      exp_t e;
      if (ii < sc_i.size() && (di >= sc_d.size() || m_streak == DMAX)) begin
        it = sc_i[ii]; ii++; m_streak = 0; m_igr++;
      end else begin
        it = sc_d[di]; di++; m_dgr++;
        if (m_streak < DMAX) m_streak++;
      end
      e.is_d = it.is_d;
      e.is_wr = it.is_d && it.wr;
      e.addr = it.addr & 32'hFFFF_FFE0;
      if (e.is_wr) begin
        e.data = it.wdata;
        ref_mem[e.addr] = it.wdata;
      end else begin
        e.data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : default_line(e.addr);
      end
      exp_q.push_back(e);
    end
    foreach (sc_i[j]) i_items.push_back(sc_i[j]);
    foreach (sc_d[j]) d_items.push_back(sc_d[j]);
    sc_i.delete(); sc_d.delete();
    while ((i_items.size() > 0 || d_items.size() > 0 || exp_q.size() > 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      chk("drain_timeout", 640'(i_items.size() + d_items.size() + exp_q.size()), 640'(0));
      finish_run();
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    logic [S_LINE-1:0] l039;
    int n;
    int beats;
    i_pmem_read = 1'b1; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'hFFFF_FFFF; d_pmem_wdata = rand_line();
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", all_outs(), 640'(0));
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1; drv_en = 1'b1;
    @(negedge clk);

    obs_own.delete();
    sc_i.push_back(mk(0, 1, 0, 32'h0000_2000, '0));
    sc_d.push_back(mk(1, 1, 0, 32'h0000_5000, '0));
    sc_d.push_back(mk(1, 0, 1, 32'h0000_6000, rand_line()));
    sc_d.push_back(mk(1, 1, 0, 32'h0000_7000, '0));
    scenario();
    if (obs_own.size() != 4) chk("order_len", 640'(obs_own.size()), 640'(4));
    else chk("order_DDID", 640'({obs_own[0], obs_own[1], obs_own[2], obs_own[3]}), 640'(4'b1101));

    l039 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    bus_mem[32'h0000_1220] = l039;
    ref_mem[32'h0000_1220] = l039;
    sc_i.push_back(mk(0, 1, 0, 32'h0000_1234, '0));
    scenario();

    sc_d.push_back(mk(1, 0, 1, 32'h8000_0040, {32{8'hA5}}));
    scenario();

    sc_d.push_back(mk(1, 1, 1, 32'h0000_9000, rand_line()));
    scenario();

    sc_i.push_back(mk(0, 1, 0, 32'h8000_0040, '0));
    scenario();
`ifdef ARB_PERF_CNT_EN
    chk("i_grant_cnt", 640'(i_grant_cnt), 640'(m_igr));
    chk("d_grant_cnt", 640'(d_grant_cnt), 640'(m_dgr));
`endif

    spur_en = 1'b1;
    for (int s = 0; s < 25; s++) begin
      int ni;
      int nd;
      ni = $urandom_range(0, 3);
      nd = $urandom_range((ni == 0) ? 1 : 0, 4);
      for (int j = 0; j < ni; j++)
        sc_i.push_back(mk(0, 1, 0, 32'h4000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31), '0));
      for (int j = 0; j < nd; j++) begin
        int op;
        op = $urandom_range(0, 2);
        sc_d.push_back(mk(1, op != 1, op != 0,
                          32'h4000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31),
                          rand_line()));
      end
      scenario();
    end
`ifdef ARB_PERF_CNT_EN
    chk("i_grant_cnt_end", 640'(i_grant_cnt), 640'(m_igr));
    chk("d_grant_cnt_end", 640'(d_grant_cnt), 640'(m_dgr));
`endif

    drv_en = 1'b0; mon_en = 1'b0; spur_en = 1'b0;
    @(negedge clk);
    d_pmem_read = 1'b1; d_pmem_write = 1'b0; d_pmem_address = 32'h0000_3000; i_pmem_read = 1'b0;
    n = 0; beats = 0;
    while (beats < 2 && n < 100) begin
      @(negedge clk); #1;
      if (bmem_read && bmem_resp) beats++;
      n++;
    end
    if (beats < 2) begin
      chk("rst_test_timeout", 640'(beats), 640'(2));
      finish_run();
    end
    @(posedge clk); #2;
    rst = 1'b0; d_pmem_read = 1'b0;
    #1 chk("rst_outputs_zero", all_outs(), 640'(0));
    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_no_resp", 640'({i_pmem_resp, d_pmem_resp}), 640'(0));
    end
    @(negedge clk);
    rst = 1'b1; m_streak = 0; m_igr = 0; m_dgr = 0;
    drv_en = 1'b1; mon_en = 1'b1; spur_en = 1'b1;
    @(negedge clk);

    sc_d.push_back(mk(1, 1, 0, 32'h0000_3000, '0));
    sc_i.push_back(mk(0, 1, 0, 32'h0000_1220, '0));
    scenario();
`ifdef ARB_PERF_CNT_EN
    chk("i_grant_cnt_post_rst", 640'(i_grant_cnt), 640'(m_igr));
    chk("d_grant_cnt_post_rst", 640'(d_grant_cnt), 640'(m_dgr));
`endif
    finish_run();
  end

endmodule
